// File: rtl/mux8_rr_arbiter_if.sv
// Purpose: bundles the eight producer ports, the downstream handshake and the
//          arbiter status outputs of mux8_rr_arbiter.
// Ports:   req/last/d/out_ready in; gnt/sel/y/y_valid/y_last/busy out (slave view).
interface mux8_rr_arbiter_if #(
    parameter int DW = 1
);
    logic [7:0]      req;
    logic [7:0]      last;
    logic [8*DW-1:0] d;
    logic            out_ready;
    logic [7:0]      gnt;
    logic [2:0]      sel;
    logic [DW-1:0]   y;
    logic            y_valid;
    logic            y_last;
    logic            busy;

    // Arbiter side.
    modport slave (
        input  req, last, d, out_ready,
        output gnt, sel, y, y_valid, y_last, busy
    );

    // Producer/consumer side.
    modport master (
        output req, last, d, out_ready,
        input  gnt, sel, y, y_valid, y_last, busy
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one 8:1 data mux; holds a grant for a whole packet.
// Latency: grant one edge after a request is seen in IDLE; y/y_valid/y_last are combinational.
// Backpressure: out_ready low stalls the owner indefinitely; other requesters wait until release.
// Ports: clk, rst_n (async active-low), bus (mux8_rr_arbiter_if.slave).
module mux8_rr_arbiter #(
    parameter int DW = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mux8_rr_arbiter_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] sel_q;
    logic [7:0] gnt_q;

    // Rotating priority search starting at ptr. Iterating from the farthest
    // offset down to zero lets the nearest requester overwrite the result.
    logic [2:0] win_idx;
    logic       win_found;
    logic [2:0] probe;

    always_comb begin
        win_idx   = ptr;
        win_found = 1'b0;
        probe     = ptr;
        for (int i = 7; i >= 0; i--) begin
            probe = ptr + 3'(i);
            if (bus.req[probe]) begin
                win_idx   = probe;
                win_found = 1'b1;
            end
        end
    end

    logic own;
    logic cur_req;
    logic cur_last;
    logic release_own;

    assign own      = (state == OWN);
    assign cur_req  = bus.req[sel_q];
    assign cur_last = bus.last[sel_q];
    // Release on the final beat actually transferring, or when the owner
    // drops its request (abandoned packet).
    assign release_own = !cur_req || (bus.out_ready && cur_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd0;
            sel_q <= 3'd0;
            gnt_q <= 8'd0;
        end else if (state == IDLE) begin
            if (win_found) begin
                state <= OWN;
                sel_q <= win_idx;
                gnt_q <= 8'd1 << win_idx;
            end
        end else begin
            if (release_own) begin
                state <= IDLE;
                gnt_q <= 8'd0;
                // The releasing port becomes lowest priority next round.
                ptr   <= sel_q + 3'd1;
            end
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = own;
    // The mux output follows sel even in IDLE; y_valid qualifies it.
    assign bus.y       = bus.d[int'(sel_q)*DW +: DW];
    assign bus.y_valid = own & cur_req;
    assign bus.y_last  = own & cur_last;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;
    localparam int DW = 8;

    logic clk;
    logic rst_n;

    mux8_rr_arbiter_if #(.DW(DW)) bus ();

    mux8_rr_arbiter #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       yv;
        logic       yl;
        logic [7:0] y;
    } cyc_t;

    typedef struct {
        logic [7:0] y;
        logic       yl;
        logic [2:0] sel;
    } beat_t;

    cyc_t  cycq[$];
    beat_t beatq[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner index (-1 when idle), priority pointer, last select.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive one cycle of inputs (called just after a falling edge), record the
    // expected outputs for that cycle, advance the model across the rising edge.
    task automatic cycle(input logic [7:0] r, input logic [7:0] l,
                         input logic [63:0] dd, input logic rdy);
        cyc_t  c;
        beat_t b;
        int    k;
        bus.req       = r;
        bus.last      = l;
        bus.d         = dd;
        bus.out_ready = rdy;
        c.busy = (m_owner >= 0);
        c.gnt  = c.busy ? (8'd1 << m_sel) : 8'd0;
        c.sel  = 3'(m_sel);
        c.y    = dd[m_sel*8 +: 8];
        c.yv   = c.busy && r[m_sel];
        c.yl   = c.busy && l[m_sel];
        cycq.push_back(c);
        if (c.yv && rdy) begin
            b.y   = c.y;
            b.yl  = c.yl;
            b.sel = c.sel;
            beatq.push_back(b);
        end
        if (!c.busy) begin
            for (k = 0; k < 8; k++)
                if (r[(m_ptr + k) % 8]) break;
            if (k < 8) begin
                m_owner = (m_ptr + k) % 8;
                m_sel   = m_owner;
            end
        end else if (!r[m_sel] || (rdy && l[m_sel])) begin
            m_ptr   = (m_sel + 1) % 8;
            m_owner = -1;
        end
        @(negedge clk);
    endtask

    // Monitor: per-cycle state check plus in-order beat scoreboard.
    cyc_t  mc;
    beat_t mb;
    always @(negedge clk) begin
        #1;
        if (rst_n && cycq.size() > 0) begin
            mc = cycq.pop_front();
            chk("gnt",     bus.gnt,     mc.gnt);
            chk("sel",     bus.sel,     mc.sel);
            chk("busy",    bus.busy,    mc.busy);
            chk("y_valid", bus.y_valid, mc.yv);
            chk("y_last",  bus.y_last,  mc.yl);
            chk("y",       bus.y,       mc.y);
        end
        if (rst_n && bus.y_valid && bus.out_ready) begin
            if (beatq.size() == 0) begin
                chk("beat_unexpected", beatq.size(), 1);
            end else begin
                mb = beatq.pop_front();
                chk("beat_data", bus.y,      mb.y);
                chk("beat_last", bus.y_last, mb.yl);
                chk("beat_port", bus.sel,    mb.sel);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [7:0] preq;
    int         own_cnt;
    int         beat;

    initial begin
        rst_n         = 1'b0;
        bus.req       = 8'hFF;
        bus.last      = 8'hFF;
        bus.d         = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt",     bus.gnt,     8'h00);
        chk("rst_sel",     bus.sel,     3'd0);
        chk("rst_y_valid", bus.y_valid, 1'b0);
        chk("rst_busy",    bus.busy,    1'b0);

        // Release reset; all ports requesting single-beat packets.
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++)
            cycle(8'hFF, 8'hFF, {$urandom, $urandom}, 1'b1);

        // Pointer wrap: port 6, then 7 and 0 from ptr=7.
        cycle(8'h40, 8'hFF, 64'h0, 1'b1);
        cycle(8'h40, 8'hFF, 64'h0, 1'b1);
        for (int i = 0; i < 4; i++)
            cycle(8'h81, 8'hFF, {$urandom, $urandom}, 1'b1);
        cycle(8'h00, 8'h00, 64'h0, 1'b1);

        // Multi-beat from port 3 with a two-cycle stall; port 5 waits.
        own_cnt = 0;
        beat    = 0;
        while (beat < 4) begin
            logic [63:0] dd;
            logic        rdy;
            dd = {$urandom, $urandom};
            dd[3*8 +: 8] = 8'hA0 + 8'(beat);
            rdy = 1'b1;
            if (m_owner == 3 && (own_cnt == 1 || own_cnt == 2)) rdy = 1'b0;
            if (bus.busy && bus.sel == 3'd3) own_cnt++;
            if (m_owner == 3 && rdy) begin
                cycle(8'h28, (beat == 3) ? 8'h08 : 8'h00, dd, rdy);
                beat++;
            end else begin
                cycle(8'h28, 8'h00, dd, rdy);
            end
        end
        chk("p3_own_cycles", own_cnt, 6);
        cycle(8'h20, 8'h20, 64'h0, 1'b1);
        cycle(8'h20, 8'h20, 64'h0, 1'b1);
        cycle(8'h00, 8'h00, 64'h0, 1'b1);

        // Abandon: port 2 drops its request, port 1 pending.
        cycle(8'h04, 8'h00, 64'h0, 1'b1);
        cycle(8'h02, 8'h00, 64'h0, 1'b1);
        cycle(8'h02, 8'h00, 64'h0, 1'b1);
        cycle(8'h02, 8'h02, 64'h0, 1'b1);
        cycle(8'h00, 8'h00, 64'h0, 1'b1);

        // Async reset during beat 2 of a 4-beat packet from port 4.
        cycle(8'h10, 8'h00, {$urandom, $urandom}, 1'b1);
        cycle(8'h10, 8'h00, {$urandom, $urandom}, 1'b1);
        bus.req       = 8'h10;
        bus.last      = 8'h00;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt",     bus.gnt,     8'h00);
        chk("arst_y_valid", bus.y_valid, 1'b0);
        chk("arst_busy",    bus.busy,    1'b0);
        chk("arst_sel",     bus.sel,     3'd0);
        @(negedge clk);
        @(negedge clk);
        m_owner = -1;
        m_ptr   = 0;
        m_sel   = 0;
        rst_n   = 1'b1;
        cycle(8'hFF, 8'hFF, {$urandom, $urandom}, 1'b1);
        cycle(8'hFF, 8'hFF, {$urandom, $urandom}, 1'b1);
        cycle(8'h00, 8'h00, 64'h0, 1'b1);

        // Randomized traffic: sticky requests, random last/ready, abandons.
        preq = 8'h00;
        for (int n = 0; n < 400; n++) begin
            int         o;
            logic [7:0] l;
            logic       rdy;
            for (int i = 0; i < 8; i++)
                if (!preq[i] && $urandom_range(3) == 0) preq[i] = 1'b1;
            if (m_owner >= 0 && $urandom_range(15) == 0) preq[m_owner] = 1'b0;
            l   = 8'($urandom) & 8'($urandom);
            rdy = ($urandom_range(3) != 0);
            o   = m_owner;
            cycle(preq, l, {$urandom, $urandom}, rdy);
            if (o >= 0 && m_owner < 0 && $urandom_range(1) == 0) preq[o] = 1'b0;
        end
        cycle(8'h00, 8'h00, 64'h0, 1'b1);
        cycle(8'h00, 8'h00, 64'h0, 1'b1);
        #2;
        chk("beatq_drained", beatq.size(), 0);
        chk("cycq_drained",  cycq.size(),  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer that shares one 8-to-1 data multiplexer between eight requesters. It grants one requester at a time, drives the 3-bit select and one-hot grant, and forwards the selected data through a valid/ready handshake. A grant is held for a multi-beat packet that ends with `last`. The block sits between eight producer ports and a single downstream consumer.

## Interface
- `DW`, default 1: data width per requester port.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  8  per-requester request/valid; `req[i]` high means beat `d[i]` is valid.
- `last`  in  8  per-requester end-of-packet flag, qualified by `req[i]`.
- `d`  in  8*DW  packed requester data; `d[i*DW +: DW]` belongs to requester i.
- `out_ready`  in  1  downstream ready.
- `gnt`  out  8  registered one-hot grant; all zero when idle.
- `sel`  out  3  registered mux select; the index of the current owner.
- `y`  out  DW  selected data, `d[sel]`; combinational from `sel` and `d`.
- `y_valid`  out  1  `req[sel]` while in OWN, else 0.
- `y_last`  out  1  `last[sel]` while in OWN, else 0.
- `busy`  out  1  high in OWN.

## Operation
- The FSM has two states: IDLE and OWN. Reset state is IDLE.
- A registered 3-bit priority pointer `ptr` resets to 0.
- **IDLE:**
  - If `req != 0`, the winner is the first index k with `req[k]` high, searching `ptr, ptr+1, …, ptr+7` modulo 8.
  - On the clock edge, `sel` takes k, `gnt` takes `1<<k`, and the FSM moves to OWN.
  - If `req == 0`, the FSM stays in IDLE; `gnt` stays 0 and `sel` holds its last value.
- **OWN:**
  - A transfer occurs in any cycle with `y_valid && out_ready`.
  - Release condition A: a transfer with `y_last` high.
  - Release condition B: `req[sel]` is low, meaning the requester abandoned the grant.
  - On release: the next state is IDLE, `gnt` goes to 0, and `ptr` takes `sel+1` (wraps 7→0).
  - Otherwise the FSM stays in OWN and `sel`/`gnt` hold.
- The downstream does not wait on stalls: `out_ready` low with `y_valid` high holds the grant indefinitely.
- Requests from other ports during OWN are ignored until IDLE. No requester is ever preempted.
- `y` always equals `d[sel*DW +: DW]`, including in IDLE. Downstream must use `y_valid` to qualify it.
- Reset values: `gnt=0`, `sel=0`, `busy=0`, `y_valid=0`, `y_last=0`, `ptr=0`, state IDLE.
- Reset assertion mid-packet forces these values immediately (asynchronous). The packet is dropped and no beat is counted.

## Timing
- Arbitration latency:
  - A request first sampled high at edge N (state IDLE) gives `gnt`/`busy` high after edge N.
  - The first beat can transfer in the cycle following edge N.
- A single-beat packet with `out_ready` high occupies the following states:
  - 1 IDLE cycle (arbitration).
  - 1 OWN cycle (transfer).
  - Back in IDLE after the next edge.
  - Minimum 2 cycles per packet.
- An n-beat packet with no stalls occupies n OWN cycles.
- There is always exactly one IDLE cycle between consecutive grants. It is the arbitration bubble, and there is no same-cycle re-grant.
- Fairness: with all 8 requesting continuously, the grant order from reset is 0,1,2,…,7,0,…. Each requester waits at most 7 packets.
- Simultaneous release and new request by the same port: that port has the lowest priority in the next arbitration.
- `sel`, `gnt` and `busy` are glitch-free registered outputs. `y`, `y_valid` and `y_last` are combinational from inputs.

## Test plan
- **Reset:** hold `rst_n=0` with `req=8'hFF`. Expect `gnt=0`, `sel=0`, `y_valid=0`. Release reset → `gnt=8'h01` one cycle later.
- **Round robin:** `req=8'hFF`, every `last=1`, `out_ready=1`. Expect `sel` to visit 0..7 then 0, with `busy` toggling 1,0 each cycle pair. Expect 8 packets in 16 cycles.
- **Pointer wrap:** after port 6 finishes, assert `req=8'b1000_0001`. Expect the grant to go to port 7, then to port 0.
- **Multi-beat with stall:**
  - Port 3 sends 4 beats, `DW=8`, data `8'hA0..8'hA3`, `last` on the 4th.
  - `out_ready` is low in cycles 2–3.
  - Expect `sel=3` held for 6 OWN cycles and y beats A0..A3 in order.
  - Port 5, requesting throughout, must not be granted until after release.
- **Abandon:** port 2 is granted, then drops `req[2]` before `last`. Expect the FSM back to IDLE next edge and `ptr=3`. Pending port 1 is granted only after ports 3..7 are found empty.
- **Async reset mid-packet:** assert `rst_n=0` between clock edges during beat 2 of a 4-beat packet. Expect `gnt=0` and `y_valid=0` immediately. After release, arbitration restarts from `ptr=0`.
